// File: rtl/sram_bridge.sv
// Core-side 32-bit request/response bridge to a 16-bit asynchronous SRAM, two halfword phases.
// Define SRAM_BRIDGE_SKIP_EN to skip write phases whose two byte enables are both zero.
module sram_bridge #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [17:0] addr,
  inout  wire  [15:0] data,
  output logic        wre,
  output logic        oute,
  output logic        hb_mask,
  output logic        lb_mask,
  output logic        chip_en
);

`ifdef SRAM_BRIDGE_SKIP_EN
  localparam bit SkipEn = 1'b1;
`else
  localparam bit SkipEn = 1'b0;
`endif

  localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StLo, StHi, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            write_q, write_d;
  logic [3:0]      be_q, be_d;
  logic [16:0]     waddr_q, waddr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [15:0]     rdata_lo_q;
  logic [31:0]     rdata_q;

  logic [17:0]     addr_q, addr_d;
  logic            wre_q, wre_d, oute_q, oute_d, hb_q, hb_d, lb_q, lb_d, ce_q, ce_d;
  logic            drive_q, drive_d;
  logic [15:0]     dout_q, dout_d;

  logic            accept, last, half_hi, in_phase, active;
  logic [1:0]      half_be;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^{req_addr[31:19], req_addr[1:0]};

  assign req_ready  = (state_q == StIdle) && !reset;
  assign resp_valid = (state_q == StResp) && !reset;
  assign resp_rdata = rdata_q;
  assign accept     = req_valid && req_ready;
  assign last       = (cnt_q == CntW'(WAIT_CYCLES - 1));

  assign addr    = addr_q;
  assign wre     = wre_q;
  assign oute    = oute_q;
  assign hb_mask = hb_q;
  assign lb_mask = lb_q;
  assign chip_en = ce_q;
  assign data    = drive_q ? dout_q : 16'hzzzz;

  // Request fields are captured only on the acceptance cycle.
  assign write_d = accept ? req_write       : write_q;
  assign be_d    = accept ? req_be          : be_q;
  assign waddr_d = accept ? req_addr[18:2]  : waddr_q;
  assign wdata_d = accept ? req_wdata       : wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (SkipEn && req_write && (req_be[1:0] == 2'b00)) begin
            state_d = (req_be[3:2] == 2'b00) ? StResp : StHi;
          end else begin
            state_d = StLo;
          end
        end
      end
      StLo: begin
        if (last) begin
          state_d = (SkipEn && write_q && (be_q[3:2] == 2'b00)) ? StResp : StHi;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHi: begin
        if (last) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // SRAM pins are registered from the next state so they change only on phase boundaries.
  always_comb begin
    half_hi  = (state_d == StHi);
    in_phase = (state_d == StLo) || (state_d == StHi);
    half_be  = half_hi ? be_d[3:2] : be_d[1:0];
    active   = in_phase && (!write_d || (half_be != 2'b00));
    addr_d   = {waddr_d, half_hi};
    ce_d     = !active;
    oute_d   = !(active && !write_d);
    wre_d    = !(active && write_d);
    lb_d     = !active || (write_d && !half_be[0]);
    hb_d     = !active || (write_d && !half_be[1]);
    drive_d  = active && write_d;
    dout_d   = half_hi ? wdata_d[31:16] : wdata_d[15:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      be_q       <= 4'h0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      rdata_lo_q <= '0;
      rdata_q    <= '0;
      addr_q     <= '0;
      wre_q      <= 1'b1;
      oute_q     <= 1'b1;
      hb_q       <= 1'b1;
      lb_q       <= 1'b1;
      ce_q       <= 1'b1;
      drive_q    <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      be_q    <= be_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      wre_q   <= wre_d;
      oute_q  <= oute_d;
      hb_q    <= hb_d;
      lb_q    <= lb_d;
      ce_q    <= ce_d;
      drive_q <= drive_d;
      dout_q  <= dout_d;
      // Read data is taken on the last clock of each phase.
      if ((state_q == StLo) && last && !write_q) begin
        rdata_lo_q <= data;
      end
      if ((state_q == StHi) && last && !write_q) begin
        rdata_q <= {data, rdata_lo_q};
      end
    end
  end

endmodule

// File: tb/tb_sram_bridge.sv
// Bench for sram_bridge: two instances (WAIT_CYCLES 1 and 3) with SRAM models, checked against
// a transaction-level model of phases, latency and memory contents.
module tb_sram_bridge;

`ifdef SRAM_BRIDGE_SKIP_EN
  localparam bit Skip = 1'b1;
`else
  localparam bit Skip = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, req_valid, req_write, sel;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;

  logic        ready_a, rv_a, wre_a, oute_a, hb_a, lb_a, ce_a;
  logic [31:0] rdata_a;
  logic [17:0] addr_a;
  wire  [15:0] data_a;
  logic        ready_b, rv_b, wre_b, oute_b, hb_b, lb_b, ce_b;
  logic [31:0] rdata_b;
  logic [17:0] addr_b;
  wire  [15:0] data_b;

  logic [15:0] mem_a [1024];
  logic [15:0] mem_b [1024];
  logic [15:0] exp_mem [2][1024];
  logic [31:0] last_rdata [2];
  int checks = 0;
  int errors = 0;

  sram_bridge #(.WAIT_CYCLES(1)) dut_a (
    .clock(clock), .reset(reset), .req_valid(req_valid && !sel), .req_ready(ready_a),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(rv_a), .resp_rdata(rdata_a), .addr(addr_a), .data(data_a), .wre(wre_a),
    .oute(oute_a), .hb_mask(hb_a), .lb_mask(lb_a), .chip_en(ce_a)
  );

  sram_bridge #(.WAIT_CYCLES(3)) dut_b (
    .clock(clock), .reset(reset), .req_valid(req_valid && sel), .req_ready(ready_b),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(rv_b), .resp_rdata(rdata_b), .addr(addr_b), .data(data_b), .wre(wre_b),
    .oute(oute_b), .hb_mask(hb_b), .lb_mask(lb_b), .chip_en(ce_b)
  );

  // Asynchronous SRAM models: read while chip and output enabled, byte writes on clock edge.
  assign data_a = (!ce_a && !oute_a) ? mem_a[addr_a[9:0]] : 16'hzzzz;
  assign data_b = (!ce_b && !oute_b) ? mem_b[addr_b[9:0]] : 16'hzzzz;

  always @(posedge clock) begin
    if (!ce_a && !wre_a) begin
      if (!lb_a) mem_a[addr_a[9:0]][7:0]  <= data_a[7:0];
      if (!hb_a) mem_a[addr_a[9:0]][15:8] <= data_a[15:8];
    end
    if (!ce_b && !wre_b) begin
      if (!lb_b) mem_b[addr_b[9:0]][7:0]  <= data_b[7:0];
      if (!hb_b) mem_b[addr_b[9:0]][15:8] <= data_b[15:8];
    end
  end

  logic        ready_m, rv_m, wre_m, oute_m, hb_m, lb_m, ce_m;
  logic [31:0] rdata_m;
  logic [17:0] addr_m;
  assign ready_m = sel ? ready_b : ready_a;
  assign rv_m    = sel ? rv_b    : rv_a;
  assign wre_m   = sel ? wre_b   : wre_a;
  assign oute_m  = sel ? oute_b  : oute_a;
  assign hb_m    = sel ? hb_b    : hb_a;
  assign lb_m    = sel ? lb_b    : lb_a;
  assign ce_m    = sel ? ce_b    : ce_a;
  assign rdata_m = sel ? rdata_b : rdata_a;
  assign addr_m  = sel ? addr_b  : addr_a;

  function automatic logic [15:0] sram_word(input int d, input logic [9:0] idx);
    return (d != 0) ? mem_b[idx] : mem_a[idx];
  endfunction

  // Word addresses 0..63 with random ignored bits above 18 and below 2.
  function automatic logic [31:0] rnd_addr();
    return {13'($urandom), 11'b0, 6'($urandom), 2'($urandom)};
  endfunction

  task automatic run_txn(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input bit hold);
    int d, w, n, lat, t, h;
    int hs [2];
    bit act;
    logic [1:0] hbe;
    logic [9:0] idx;
    logic [31:0] exp_rd;
    d = sel ? 1 : 0;
    w = sel ? 3 : 1;
    n = 0;
    for (int p = 0; p < 2; p++) begin
      hbe = (p != 0) ? be[3:2] : be[1:0];
      if (!wr || !Skip || (hbe != 2'b00)) begin
        hs[n] = p;
        n++;
      end
    end
    lat = n * w + 1;
    t = 0;
    while (!ready_m && t < 50) begin
      @(negedge clock);
      t++;
    end
    checks++;
    if (ready_m !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait dut%0d got %b want 1", d, ready_m);
    end
    req_write = wr; req_addr = a; req_wdata = wd; req_be = be; req_valid = 1'b1;
    @(negedge clock);
    req_valid = hold;
    req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    exp_rd = wr ? last_rdata[d]
                : {exp_mem[d][{a[10:2], 1'b1}], exp_mem[d][{a[10:2], 1'b0}]};
    for (int k = 1; k <= lat; k++) begin
      if (k < lat) begin
        h = hs[(k - 1) / w];
        hbe = (h != 0) ? be[3:2] : be[1:0];
        act = !wr || (hbe != 2'b00);
        checks++;
        if ({ready_m, rv_m, ce_m, oute_m, wre_m} !==
            {2'b00, !act, !(act && !wr), !(act && wr)}) begin
          errors++;
          $display("FAIL phase_strobes dut%0d cyc%0d got %b want %b", d, k,
                   {ready_m, rv_m, ce_m, oute_m, wre_m},
                   {2'b00, !act, !(act && !wr), !(act && wr)});
        end
        checks++;
        if (addr_m !== {a[18:2], h[0]}) begin
          errors++;
          $display("FAIL phase_addr dut%0d cyc%0d got %h want %h", d, k, addr_m,
                   {a[18:2], h[0]});
        end
        if (act) begin
          checks++;
          if ({hb_m, lb_m} !== (wr ? ~hbe : 2'b00)) begin
            errors++;
            $display("FAIL phase_masks dut%0d cyc%0d got %b want %b", d, k, {hb_m, lb_m},
                     wr ? ~hbe : 2'b00);
          end
        end
      end else begin
        checks++;
        if ({ready_m, rv_m, ce_m, oute_m, wre_m} !== 5'b01111) begin
          errors++;
          $display("FAIL resp_strobes dut%0d cyc%0d got %b want 01111", d, k,
                   {ready_m, rv_m, ce_m, oute_m, wre_m});
        end
        checks++;
        if (rdata_m !== exp_rd) begin
          errors++;
          $display("FAIL resp_rdata dut%0d got %h want %h", d, rdata_m, exp_rd);
        end
      end
      @(negedge clock);
    end
    checks++;
    if ({ready_m, rv_m} !== 2'b10) begin
      errors++;
      $display("FAIL back_to_idle dut%0d got %b want 10", d, {ready_m, rv_m});
    end
    for (int p = 0; p < 2; p++) begin
      idx = {a[10:2], p[0]};
      hbe = (p != 0) ? be[3:2] : be[1:0];
      if (wr && hbe[0]) exp_mem[d][idx][7:0]  = wd[p*16 +: 8];
      if (wr && hbe[1]) exp_mem[d][idx][15:8] = wd[p*16+8 +: 8];
      checks++;
      if (sram_word(d, idx) !== exp_mem[d][idx]) begin
        errors++;
        $display("FAIL sram_contents dut%0d idx %0d got %h want %h", d, idx,
                 sram_word(d, idx), exp_mem[d][idx]);
      end
    end
    if (!wr) last_rdata[d] = exp_rd;
  endtask

  task automatic test_reset();
    req_valid = 1'b1; req_write = 1'b1; req_be = 4'hF;
    @(negedge clock);
    @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if ({ready_m, rv_m, ce_m, oute_m, wre_m, hb_m, lb_m} !== 7'b0011111) begin
        errors++;
        $display("FAIL reset_strobes dut%0d got %b want 0011111", s,
                 {ready_m, rv_m, ce_m, oute_m, wre_m, hb_m, lb_m});
      end
      checks++;
      if ({addr_m, rdata_m} !== 50'h0) begin
        errors++;
        $display("FAIL reset_addr_rdata dut%0d got %h/%h want 0/0", s, addr_m, rdata_m);
      end
    end
    req_valid = 1'b0;
    reset = 1'b0;
    sel = 1'b0;
    @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if (ready_m !== 1'b1) begin
        errors++;
        $display("FAIL ready_after_reset dut%0d got %b want 1", s, ready_m);
      end
    end
    sel = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_fill();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 64; i++) run_txn(1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0);
    end
  endtask

  task automatic test_directed();
    sel = 1'b0;
    run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
    run_txn(1'b0, 32'h0000_0010, $urandom, 4'($urandom), 1'b0);
    checks++;
    if (rdata_m !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL read_beef got %h want deadbeef", rdata_m);
    end
    run_txn(1'b1, 32'h0000_0004, 32'h1234_5678, 4'hF, 1'b0);
    checks++;
    if ({sram_word(0, 10'd3), sram_word(0, 10'd2)} !== 32'h1234_5678) begin
      errors++;
      $display("FAIL write_full got %h want 12345678",
               {sram_word(0, 10'd3), sram_word(0, 10'd2)});
    end
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      run_txn(1'b1, 32'h0, $urandom, 4'b1100, 1'b0);
      run_txn(1'b1, 32'h8, $urandom, 4'b0011, 1'b0);
      run_txn(1'b1, rnd_addr(), $urandom, 4'b0000, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    sel = 1'b1;
    run_txn(1'b0, rnd_addr(), $urandom, 4'($urandom), 1'b1);
    run_txn(1'b0, rnd_addr(), $urandom, 4'($urandom), 1'b1);
    run_txn(1'b1, rnd_addr(), $urandom, 4'($urandom), 1'b1);
    run_txn(1'b0, rnd_addr(), $urandom, 4'($urandom), 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      sel = 1'($urandom);
      run_txn(1'($urandom), rnd_addr(), $urandom, 4'($urandom), 1'b0);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] a;
    a = 32'h0000_0014;
    sel = 1'b0;
    req_write = 1'b1; req_addr = a; req_wdata = $urandom; req_be = 4'hF; req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    checks++;
    if ({ce_m, wre_m, rv_m} !== 3'b000) begin
      errors++;
      $display("FAIL abort_pre got %b want 000", {ce_m, wre_m, rv_m});
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({ready_m, rv_m, ce_m, oute_m, wre_m, hb_m, lb_m} !== 7'b0011111) begin
      errors++;
      $display("FAIL abort_strobes got %b want 0011111",
               {ready_m, rv_m, ce_m, oute_m, wre_m, hb_m, lb_m});
    end
    checks++;
    if ({addr_m, rdata_m} !== 50'h0) begin
      errors++;
      $display("FAIL abort_addr_rdata got %h/%h want 0/0", addr_m, rdata_m);
    end
    @(negedge clock);
    checks++;
    if (rv_m !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_resp got %b want 0", rv_m);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({ready_m, rv_m} !== 2'b10) begin
      errors++;
      $display("FAIL abort_ready got %b want 10", {ready_m, rv_m});
    end
    last_rdata[0] = '0;
    last_rdata[1] = '0;
    run_txn(1'b1, a, $urandom, 4'hF, 1'b0);
    run_txn(1'b0, a, $urandom, 4'hF, 1'b0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_be = '0; sel = 1'b0;
    last_rdata[0] = '0;
    last_rdata[1] = '0;
    test_reset();
    test_fill();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
